full_err_lanes: RTL and testbench

Parametrised successor to the single-lane error stage. Joins LANES-wide network output beats with expected-value beats, emits a saturated per-lane error stream through an internal FIFO, and in loss mode accumulates a per-frame sum of squared errors. Sits between the last network stage and the back-propagation/training controller.

---
 rtl/full_err_lanes_pkg.sv | 14 +
 rtl/full_err_lanes_if.sv | 49 ++++
 rtl/full_err_lanes_fifo.sv | 49 ++++
 rtl/full_err_lanes.sv | 147 ++++++++++++++
 tb/tb_full_err_lanes.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/full_err_lanes_pkg.sv
// Shared types for the multi-lane error/loss stage: mode select and loss-frame state.
package full_err_lanes_pkg;

  typedef enum logic {
    ERR_ONLY = 1'b0,
    ERR_LOSS = 1'b1
  } err_mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    OPEN = 1'b1
  } frame_state_t;

endpackage

// File: rtl/full_err_lanes_if.sv
// Beat-level bundle between the network tail, the error stage and the training controller.
// master drives beats and consumes results; slave is the error stage itself.
interface full_err_lanes_if #(
  parameter int LANES     = 4,
  parameter int WIDTH     = 16,
  parameter int ACC_WIDTH = 48
);

  logic                   mode;
  logic                   loss_flush;
  logic [LANES*WIDTH-1:0] expected;
  logic                   expected_fst;
  logic                   expected_vld;
  logic                   expected_rdy;
  logic [LANES*WIDTH-1:0] stage_data_out;
  logic                   stage_data_out_fst;
  logic                   stage_data_out_vld;
  logic                   stage_data_out_rdy;
  logic [LANES*WIDTH-1:0] stage_error;
  logic                   stage_error_fst;
  logic                   stage_error_vld;
  logic                   stage_error_rdy;
  logic [ACC_WIDTH-1:0]   loss;
  logic                   loss_vld;
  logic                   fst_mismatch;

  modport master (
    output mode, loss_flush,
    output expected, expected_fst, expected_vld,
    input  expected_rdy,
    output stage_data_out, stage_data_out_fst, stage_data_out_vld,
    input  stage_data_out_rdy,
    input  stage_error, stage_error_fst, stage_error_vld,
    output stage_error_rdy,
    input  loss, loss_vld, fst_mismatch
  );

  modport slave (
    input  mode, loss_flush,
    input  expected, expected_fst, expected_vld,
    output expected_rdy,
    input  stage_data_out, stage_data_out_fst, stage_data_out_vld,
    output stage_data_out_rdy,
    output stage_error, stage_error_fst, stage_error_vld,
    input  stage_error_rdy,
    output loss, loss_vld, fst_mismatch
  );

endinterface

// File: rtl/full_err_lanes_fifo.sv
// Synchronous FIFO with the head read straight from the storage registers; push->visible next cycle.
// Push is ignored when full, pop when empty; full is independent of the same-cycle pop.
module full_err_lanes_fifo #(
  parameter int DW    = 65,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_push_dat,
  output logic          o_full,
  input  logic          i_pop,
  output logic [DW-1:0] o_head_dat,
  output logic          o_vld
);

  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full     = (r_count == (AW+1)'(DEPTH));
  assign o_vld      = (r_count != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign w_push     = i_push & ~o_full;
  assign w_pop      = i_pop & o_vld;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_count <= r_count + 1'b1;
      else if (w_pop && !w_push) r_count <= r_count - 1'b1;
    end
  end

endmodule

// File: rtl/full_err_lanes.sv
// Joins network and expected beats into saturated per-lane errors (1 cycle, FIFO-buffered) and
// per-frame saturated sum of squares (close -> loss_vld 3 cycles later); join stalls only on FIFO full.
module full_err_lanes
  import full_err_lanes_pkg::*;
#(
  parameter int LANES     = 4,
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 4,
  parameter int ACC_WIDTH = 48
) (
  input logic              clk,
  input logic              reset,
  full_err_lanes_if.slave  bus
);

  localparam int SQW  = 2*WIDTH + $clog2(LANES);
  localparam int SUMW = ((ACC_WIDTH > SQW) ? ACC_WIDTH : SQW) + 1;
  localparam int DW   = LANES*WIDTH + 1;
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic                   w_full;
  logic                   w_fire;
  logic                   w_fst_fire;
  logic                   w_open;
  logic                   w_close;
  logic [LANES*WIDTH-1:0] w_err;
  logic [SQW-1:0]         w_sq [LANES];
  logic [SQW-1:0]         w_sq_sum;
  logic [DW-1:0]          w_head;
  logic                   w_head_vld;

  frame_state_t           r_state;
  err_mode_t              r_mode;
  logic                   r_fst_mm;
  logic                   r_a_vld;
  logic                   r_a_close;
  logic [SQW-1:0]         r_a_sq;
  logic                   r_b_close;
  logic [ACC_WIDTH-1:0]   r_b_snap;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [ACC_WIDTH-1:0]   r_loss;
  logic                   r_loss_vld;

  // Ready is held low through reset and never looks at the consumer's ready.
  assign bus.expected_rdy       = reset & bus.stage_data_out_vld & ~w_full;
  assign bus.stage_data_out_rdy = reset & bus.expected_vld & ~w_full;
  assign w_fire     = reset & bus.expected_vld & bus.stage_data_out_vld & ~w_full;
  assign w_fst_fire = w_fire & bus.stage_data_out_fst;
  assign w_open     = (r_state == OPEN) && (r_mode == ERR_LOSS);
  assign w_close    = w_open & (w_fst_fire | bus.loss_flush);

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [WIDTH-1:0]          w_a;
    logic [WIDTH-1:0]          w_b;
    logic [WIDTH:0]            w_diff;
    logic signed [WIDTH-1:0]   w_sat;
    logic signed [2*WIDTH-1:0] w_prod;

    assign w_a    = bus.stage_data_out[g*WIDTH +: WIDTH];
    assign w_b    = bus.expected[g*WIDTH +: WIDTH];
    assign w_diff = {w_a[WIDTH-1], w_a} - {w_b[WIDTH-1], w_b};
    // Top two bits disagree only when the difference left the WIDTH-bit range.
    assign w_sat  = (w_diff[WIDTH] == w_diff[WIDTH-1]) ? w_diff[WIDTH-1:0]
                  : (w_diff[WIDTH] ? MINV : MAXV);
    assign w_prod = (2*WIDTH)'(w_sat) * (2*WIDTH)'(w_sat);
    assign w_err[g*WIDTH +: WIDTH] = w_sat;
    assign w_sq[g] = SQW'($unsigned(w_prod));
  end

  always_comb begin
    w_sq_sum = '0;
    for (int i = 0; i < LANES; i++) w_sq_sum = w_sq_sum + w_sq[i];
  end

  function automatic logic [ACC_WIDTH-1:0] sat_add(input logic [ACC_WIDTH-1:0] base,
                                                   input logic [SQW-1:0] inc);
    logic [SUMW-1:0] s;
    s = SUMW'(base) + SUMW'(inc);
    if (s > SUMW'({ACC_WIDTH{1'b1}})) return '1;
    return s[ACC_WIDTH-1:0];
  endfunction

  full_err_lanes_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_push     (w_fire),
    .i_push_dat ({bus.stage_data_out_fst, w_err}),
    .o_full     (w_full),
    .i_pop      (bus.stage_error_rdy),
    .o_head_dat (w_head),
    .o_vld      (w_head_vld)
  );

  assign bus.stage_error     = w_head[LANES*WIDTH-1:0];
  assign bus.stage_error_fst = w_head[DW-1];
  assign bus.stage_error_vld = w_head_vld;
  assign bus.loss            = r_loss;
  assign bus.loss_vld        = r_loss_vld;
  assign bus.fst_mismatch    = r_fst_mm;

  // Close marker travels with the beat that triggered it, so the snapshot in stage B
  // already contains every earlier beat and the closing fst beat seeds the new frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_mode     <= ERR_ONLY;
      r_fst_mm   <= 1'b0;
      r_a_vld    <= 1'b0;
      r_a_close  <= 1'b0;
      r_a_sq     <= '0;
      r_b_close  <= 1'b0;
      r_b_snap   <= '0;
      r_acc      <= '0;
      r_loss     <= '0;
      r_loss_vld <= 1'b0;
    end else begin
      if (w_fire && (bus.expected_fst != bus.stage_data_out_fst)) r_fst_mm <= 1'b1;

      if (w_fst_fire) begin
        r_mode  <= err_mode_t'(bus.mode);
        r_state <= bus.mode ? OPEN : IDLE;
      end else if (w_close) begin
        r_state <= IDLE;
      end

      r_a_vld   <= w_fire & (w_fst_fire ? bus.mode : w_open);
      r_a_close <= w_close;
      r_a_sq    <= w_sq_sum;

      r_b_close <= r_a_close;
      if (r_a_close) begin
        r_b_snap <= r_acc;
        r_acc    <= r_a_vld ? sat_add('0, r_a_sq) : '0;
      end else if (r_a_vld) begin
        r_acc    <= sat_add(r_acc, r_a_sq);
      end

      r_loss_vld <= r_b_close;
      if (r_b_close) r_loss <= r_b_snap;
    end
  end

endmodule

// File: tb/tb_full_err_lanes.sv
// Directed bench for full_err_lanes: saturation, backpressure, loss framing, flush, mismatch, reset.
module tb_full_err_lanes;

  localparam int LANES     = 4;
  localparam int WIDTH     = 16;
  localparam int DEPTH     = 4;
  localparam int ACC_WIDTH = 33;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  full_err_lanes_if #(.LANES(LANES), .WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

  full_err_lanes #(
    .LANES     (LANES),
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [63:0] a, input logic [63:0] b,
                       input logic afst, input logic bfst, input logic v);
    bus.stage_data_out     = a;
    bus.stage_data_out_fst = afst;
    bus.stage_data_out_vld = v;
    bus.expected           = b;
    bus.expected_fst       = bfst;
    bus.expected_vld       = v;
  endtask

  function automatic logic [63:0] lanes4(input logic [15:0] l3, input logic [15:0] l2,
                                         input logic [15:0] l1, input logic [15:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  initial begin
    reset               = 1'b0;
    bus.mode            = 1'b0;
    bus.loss_flush      = 1'b0;
    bus.stage_error_rdy = 1'b1;
    drive(lanes4(16'd1, 16'd1, 16'd1, 16'd1), 64'd0, 1'b0, 1'b0, 1'b1);
    tick();
    tick();
    check("rst_exp_rdy", 64'(bus.expected_rdy), 64'd0);
    check("rst_sdo_rdy", 64'(bus.stage_data_out_rdy), 64'd0);
    check("rst_err_vld", 64'(bus.stage_error_vld), 64'd0);
    check("rst_err", 64'(bus.stage_error), 64'd0);
    check("rst_err_fst", 64'(bus.stage_error_fst), 64'd0);
    check("rst_loss", 64'(bus.loss), 64'd0);
    check("rst_loss_vld", 64'(bus.loss_vld), 64'd0);
    check("rst_fst_mm", 64'(bus.fst_mismatch), 64'd0);
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();

    // Saturating subtract: 7FFF-(-1), 8000-1, 5-3, 0-7FFF.
    drive(lanes4(16'h0000, 16'h0005, 16'h8000, 16'h7FFF),
          lanes4(16'h7FFF, 16'h0003, 16'h0001, 16'hFFFF), 1'b1, 1'b1, 1'b1);
    #1;
    check("sat_exp_rdy", 64'(bus.expected_rdy), 64'd1);
    check("sat_sdo_rdy", 64'(bus.stage_data_out_rdy), 64'd1);
    check("sat_vld_before", 64'(bus.stage_error_vld), 64'd0);
    tick();
    check("sat_vld_after", 64'(bus.stage_error_vld), 64'd1);
    check("sat_err", 64'(bus.stage_error), lanes4(16'h8001, 16'h0002, 16'h8000, 16'h7FFF));
    check("sat_err_fst", 64'(bus.stage_error_fst), 64'd1);
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("sat_drained", 64'(bus.stage_error_vld), 64'd0);

    // Backpressure: four beats fill the FIFO, the fifth waits.
    bus.stage_error_rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(lanes4(16'd0, 16'd0, 16'd0, 16'(k + 10)), 64'd0, 1'b0, 1'b0, 1'b1);
      #1;
      check("bp_rdy_accept", 64'(bus.expected_rdy), 64'd1);
      tick();
    end
    drive(lanes4(16'd0, 16'd0, 16'd0, 16'd14), 64'd0, 1'b0, 1'b0, 1'b1);
    #1;
    check("bp_full_exp_rdy", 64'(bus.expected_rdy), 64'd0);
    check("bp_full_sdo_rdy", 64'(bus.stage_data_out_rdy), 64'd0);
    check("bp_head0", 64'(bus.stage_error), lanes4(16'd0, 16'd0, 16'd0, 16'd10));
    tick();
    check("bp_head0_stable", 64'(bus.stage_error), lanes4(16'd0, 16'd0, 16'd0, 16'd10));
    bus.stage_error_rdy = 1'b1;
    #1;
    check("bp_rdy_not_comb", 64'(bus.expected_rdy), 64'd0);
    tick();
    check("bp_head1", 64'(bus.stage_error), lanes4(16'd0, 16'd0, 16'd0, 16'd11));
    check("bp_rdy_back", 64'(bus.expected_rdy), 64'd1);
    tick();
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    check("bp_head2", 64'(bus.stage_error), lanes4(16'd0, 16'd0, 16'd0, 16'd12));
    tick();
    check("bp_head3", 64'(bus.stage_error), lanes4(16'd0, 16'd0, 16'd0, 16'd13));
    tick();
    check("bp_head4", 64'(bus.stage_error), lanes4(16'd0, 16'd0, 16'd0, 16'd14));
    tick();
    check("bp_empty", 64'(bus.stage_error_vld), 64'd0);

    // Loss frame: two beats of e=3 (36 each) closed by an fst beat of e=1.
    bus.mode = 1'b1;
    drive(lanes4(16'd3, 16'd3, 16'd3, 16'd3), 64'd0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(lanes4(16'd3, 16'd3, 16'd3, 16'd3), 64'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(lanes4(16'd1, 16'd1, 16'd1, 16'd1), 64'd0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    check("loss_t1", 64'(bus.loss_vld), 64'd0);
    tick();
    check("loss_t2", 64'(bus.loss_vld), 64'd0);
    tick();
    check("loss_t3_vld", 64'(bus.loss_vld), 64'd1);
    check("loss_t3_val", 64'(bus.loss), 64'd72);
    tick();
    check("loss_pulse_end", 64'(bus.loss_vld), 64'd0);
    check("loss_hold", 64'(bus.loss), 64'd72);

    // Flush coincident with an fst beat closes once; the beat (16) starts the next frame.
    drive(lanes4(16'd2, 16'd2, 16'd2, 16'd2), 64'd0, 1'b1, 1'b1, 1'b1);
    bus.loss_flush = 1'b1;
    tick();
    bus.loss_flush = 1'b0;
    drive(lanes4(16'd1, 16'd1, 16'd1, 16'd1), 64'd0, 1'b0, 1'b0, 1'b1);
    check("fl_t1", 64'(bus.loss_vld), 64'd0);
    tick();
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    bus.loss_flush = 1'b1;
    check("fl_t2", 64'(bus.loss_vld), 64'd0);
    tick();
    bus.loss_flush = 1'b0;
    check("fl_close1_vld", 64'(bus.loss_vld), 64'd1);
    check("fl_close1_val", 64'(bus.loss), 64'd4);
    tick();
    check("fl_single_pulse", 64'(bus.loss_vld), 64'd0);
    tick();
    check("fl_close2_vld", 64'(bus.loss_vld), 64'd1);
    check("fl_close2_val", 64'(bus.loss), 64'd20);
    tick();
    check("fl_close2_end", 64'(bus.loss_vld), 64'd0);

    // Accumulator saturation: two beats of 4*(2^15)^2 = 2^32 overflow a 33-bit accumulator.
    drive(lanes4(16'h8000, 16'h8000, 16'h8000, 16'h8000), 64'd0, 1'b1, 1'b1, 1'b1);
    tick();
    check("accsat_err", 64'(bus.stage_error), 64'h8000_8000_8000_8000);
    drive(lanes4(16'h8000, 16'h8000, 16'h8000, 16'h8000), 64'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    bus.loss_flush = 1'b1;
    tick();
    bus.loss_flush = 1'b0;
    tick();
    tick();
    check("accsat_vld", 64'(bus.loss_vld), 64'd1);
    check("accsat_val", 64'(bus.loss), 64'h1_FFFF_FFFF);

    // Error-only frames never produce loss.
    bus.mode = 1'b0;
    drive(lanes4(16'd1, 16'd1, 16'd1, 16'd1), 64'd0, 1'b1, 1'b1, 1'b1);
    tick();
    check("eonly_t1", 64'(bus.loss_vld), 64'd0);
    tick();
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    bus.loss_flush = 1'b1;
    tick();
    bus.loss_flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check("eonly_no_loss", 64'(bus.loss_vld), 64'd0);
      tick();
    end
    check("eonly_loss_hold", 64'(bus.loss), 64'h1_FFFF_FFFF);

    // fst disagreement is sticky; stage_data_out_fst goes to the FIFO.
    check("mm_clear", 64'(bus.fst_mismatch), 64'd0);
    drive(lanes4(16'd4, 16'd4, 16'd4, 16'd4), 64'd0, 1'b0, 1'b1, 1'b1);
    tick();
    check("mm_set", 64'(bus.fst_mismatch), 64'd1);
    check("mm_err_fst", 64'(bus.stage_error_fst), 64'd0);
    check("mm_err", 64'(bus.stage_error), lanes4(16'd4, 16'd4, 16'd4, 16'd4));
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    tick();
    check("mm_sticky", 64'(bus.fst_mismatch), 64'd1);

    // Reset mid-frame with FIFO occupied.
    bus.mode = 1'b1;
    bus.stage_error_rdy = 1'b0;
    drive(lanes4(16'd3, 16'd3, 16'd3, 16'd3), 64'd0, 1'b1, 1'b1, 1'b1);
    tick();
    drive(lanes4(16'd3, 16'd3, 16'd3, 16'd3), 64'd0, 1'b0, 1'b0, 1'b1);
    tick();
    drive(64'd0, 64'd0, 1'b0, 1'b0, 1'b0);
    check("mr_fifo_busy", 64'(bus.stage_error_vld), 64'd1);
    reset = 1'b0;
    tick();
    check("mr_fifo_empty", 64'(bus.stage_error_vld), 64'd0);
    check("mr_err_zero", 64'(bus.stage_error), 64'd0);
    check("mr_mm_clear", 64'(bus.fst_mismatch), 64'd0);
    check("mr_loss_zero", 64'(bus.loss), 64'd0);
    reset = 1'b1;
    bus.loss_flush = 1'b1;
    tick();
    bus.loss_flush = 1'b0;
    for (int k = 0; k < 4; k++) begin
      check("mr_no_loss", 64'(bus.loss_vld), 64'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
